ysyx_22040632_div_ctrl: RTL and testbench

Multi-cycle divide/remainder controller for the RV64IM core. It accepts DIV/DIVU/REM/REMU and their W variants from the EX stage and sequences a radix-2 restoring divider. It holds the pipeline through `alu_busy` while it works. It also arbitrates the single register-file write port between normal writeback and the divider result.

---
 rtl/ysyx_22040632_div_pkg.sv | 38 +++
 rtl/ysyx_22040632_div_core.sv | 48 ++++
 rtl/ysyx_22040632_div_ctrl.sv | 167 ++++++++++++++++
 tb/tb_ysyx_22040632_div_ctrl.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22040632_div_pkg.sv
// Shared types for the RV64IM divide/remainder controller.
// Op encoding: bit2 = 32-bit (W) form, bit1 = remainder, bit0 = unsigned.
package ysyx_22040632_div_pkg;

   typedef enum logic [2:0] {
      OP_DIV   = 3'd0,
      OP_DIVU  = 3'd1,
      OP_REM   = 3'd2,
      OP_REMU  = 3'd3,
      OP_DIVW  = 3'd4,
      OP_DIVUW = 3'd5,
      OP_REMW  = 3'd6,
      OP_REMUW = 3'd7
   } div_op_t;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_PREP = 3'd1,
      S_CALC = 3'd2,
      S_FIX  = 3'd3,
      S_DONE = 3'd4
   } div_state_t;

   localparam int DIV_W_ITER = 32;

   function automatic logic op_is_w(input div_op_t op);
      return op[2];
   endfunction

   function automatic logic op_is_rem(input div_op_t op);
      return op[1];
   endfunction

   function automatic logic op_is_signed(input div_op_t op);
      return ~op[0];
   endfunction

endpackage

// File: rtl/ysyx_22040632_div_core.sv
// Radix-2 restoring divide datapath: rem/quot/divisor registers and one
// shift-subtract step per cycle while step_i is high.
module ysyx_22040632_div_core #(
   parameter int XLEN = 64
) (
   input  logic            clk,
   input  logic            rrst_n,
   input  logic            load_i,
   input  logic            step_i,
   input  logic [XLEN-1:0] dividend_i,
   input  logic [XLEN-1:0] divisor_i,
   output logic [XLEN-1:0] quot_o,
   output logic [XLEN-1:0] rem_o
);

   logic [XLEN-1:0] rem_q, quot_q, dvs_q;
   logic [XLEN-1:0] rem_d, quot_d;
   logic [XLEN:0]   shift_s, diff_s;
   logic            ge_s;

   // rem < divisor always holds, so the borrow bit alone decides rem >= divisor
   always_comb begin
      shift_s = {rem_q, quot_q[XLEN-1]};
      diff_s  = shift_s - {1'b0, dvs_q};
      ge_s    = ~diff_s[XLEN];
      rem_d   = ge_s ? diff_s[XLEN-1:0] : shift_s[XLEN-1:0];
      quot_d  = {quot_q[XLEN-2:0], ge_s};
   end

   always_ff @(posedge clk) begin
      if (!rrst_n) begin
         rem_q  <= '0;
         quot_q <= '0;
         dvs_q  <= '0;
      end else if (load_i) begin
         rem_q  <= '0;
         quot_q <= dividend_i;
         dvs_q  <= divisor_i;
      end else if (step_i) begin
         rem_q  <= rem_d;
         quot_q <= quot_d;
      end
   end

   assign quot_o = quot_q;
   assign rem_o  = rem_q;

endmodule

// File: rtl/ysyx_22040632_div_ctrl.sv
// Divide/remainder sequencer: FSM, iteration counter, sign handling and the
// shared register-file write-port arbiter (normal writeback always wins).
module ysyx_22040632_div_ctrl
   import ysyx_22040632_div_pkg::*;
#(
   parameter int XLEN  = 64,
   parameter int CNT_W = 7
) (
   input  logic            clk,
   input  logic            rrst_n,
   input  logic            flush,
   input  logic            op_valid,
   input  logic [2:0]      op,
   input  logic [4:0]      op_rd,
   input  logic [XLEN-1:0] op_src1,
   input  logic [XLEN-1:0] op_src2,
   output logic            alu_busy,
   input  logic            wb_ena,
   input  logic [4:0]      wb_addr,
   input  logic [XLEN-1:0] wb_data,
   output logic            wr_ena,
   output logic [4:0]      wr_addr,
   output logic [XLEN-1:0] wr_data
);

   localparam logic [XLEN-1:0] MIN_D = {1'b1, {(XLEN-1){1'b0}}};
   localparam logic [XLEN-1:0] MIN_W = {{(XLEN-31){1'b1}}, {31{1'b0}}};

   div_state_t       state_q;
   logic [CNT_W-1:0] cnt_q;
   div_op_t          op_q;
   logic [4:0]       rd_q;
   logic [XLEN-1:0]  src1_q, src2_q, res_q;
   logic             qneg_q, rneg_q;

   logic            w_s, rem_s, sgn_s, sign1_s, sign2_s, zero_s, ovf_s;
   logic [XLEN-1:0] a_ext_s, b_ext_s, a_abs_s, b_abs_s, dvd_s;
   logic [XLEN-1:0] spec_res_s, fix_res_s, q_fix_s, r_fix_s;
   logic [XLEN-1:0] quot_s, rem_core_s;
   logic            load_s, step_s, div_wr_s;

   function automatic logic [XLEN-1:0] w_ext(input logic w, input logic [XLEN-1:0] v);
      return w ? {{(XLEN-32){v[31]}}, v[31:0]} : v;
   endfunction

   // W dividends sit in the upper half so 32 steps consume all their bits
   always_comb begin
      w_s     = op_is_w(op_q);
      rem_s   = op_is_rem(op_q);
      sgn_s   = op_is_signed(op_q);
      a_ext_s = w_s ? {{(XLEN-32){sgn_s & src1_q[31]}}, src1_q[31:0]} : src1_q;
      b_ext_s = w_s ? {{(XLEN-32){sgn_s & src2_q[31]}}, src2_q[31:0]} : src2_q;
      sign1_s = sgn_s & a_ext_s[XLEN-1];
      sign2_s = sgn_s & b_ext_s[XLEN-1];
      a_abs_s = sign1_s ? -a_ext_s : a_ext_s;
      b_abs_s = sign2_s ? -b_ext_s : b_ext_s;
      dvd_s   = w_s ? (a_abs_s << 32) : a_abs_s;
      zero_s  = (b_ext_s == '0);
      ovf_s   = sgn_s & (a_ext_s == (w_s ? MIN_W : MIN_D)) & (&b_ext_s);
      if (zero_s) begin
         spec_res_s = w_ext(w_s, rem_s ? a_ext_s : '1);
      end else begin
         spec_res_s = w_ext(w_s, rem_s ? '0 : a_ext_s);
      end
      q_fix_s   = qneg_q ? -quot_s : quot_s;
      r_fix_s   = rneg_q ? -rem_core_s : rem_core_s;
      fix_res_s = w_ext(w_s, rem_s ? r_fix_s : q_fix_s);
   end

   assign load_s = (state_q == S_PREP) && !flush;
   assign step_s = (state_q == S_CALC);

   ysyx_22040632_div_core #(.XLEN(XLEN)) u_core (
      .clk        (clk),
      .rrst_n     (rrst_n),
      .load_i     (load_s),
      .step_i     (step_s),
      .dividend_i (dvd_s),
      .divisor_i  (b_abs_s),
      .quot_o     (quot_s),
      .rem_o      (rem_core_s)
   );

   always_ff @(posedge clk) begin
      if (!rrst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         op_q    <= OP_DIV;
         rd_q    <= 5'd0;
         src1_q  <= '0;
         src2_q  <= '0;
         res_q   <= '0;
         qneg_q  <= 1'b0;
         rneg_q  <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (op_valid && !flush) begin
                  op_q    <= div_op_t'(op);
                  rd_q    <= op_rd;
                  src1_q  <= op_src1;
                  src2_q  <= op_src2;
                  state_q <= S_PREP;
               end
            end
            S_PREP: begin
               if (flush) begin
                  state_q <= S_IDLE;
               end else if (zero_s || ovf_s) begin
                  res_q   <= spec_res_s;
                  state_q <= S_DONE;
               end else begin
                  qneg_q  <= sign1_s ^ sign2_s;
                  rneg_q  <= sign1_s;
                  cnt_q   <= w_s ? CNT_W'(DIV_W_ITER) : CNT_W'(XLEN);
                  state_q <= S_CALC;
               end
            end
            S_CALC: begin
               if (flush) begin
                  state_q <= S_IDLE;
               end else begin
                  cnt_q <= cnt_q - CNT_W'(1);
                  if (cnt_q == CNT_W'(1)) begin
                     state_q <= S_FIX;
                  end
               end
            end
            S_FIX: begin
               if (flush) begin
                  state_q <= S_IDLE;
               end else begin
                  res_q   <= fix_res_s;
                  state_q <= S_DONE;
               end
            end
            // flush is ignored here: the result is architecturally committed
            S_DONE: begin
               if ((rd_q == 5'd0) || !wb_ena) begin
                  state_q <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign div_wr_s = rrst_n && (state_q == S_DONE) && !wb_ena && (rd_q != 5'd0);

   always_comb begin
      wr_ena = wb_ena | div_wr_s;
      if (wb_ena) begin
         wr_addr = wb_addr;
         wr_data = wb_data;
      end else if (div_wr_s) begin
         wr_addr = rd_q;
         wr_data = res_q;
      end else begin
         wr_addr = 5'd0;
         wr_data = '0;
      end
      alu_busy = ((state_q == S_IDLE) && op_valid)
               || (state_q == S_PREP) || (state_q == S_CALC) || (state_q == S_FIX)
               || ((state_q == S_DONE) && !div_wr_s);
   end

endmodule

// File: tb/tb_ysyx_22040632_div_ctrl.sv
// Scoreboard bench for the divide controller: stimulus pushes expected
// writes (address, data, cycle); a negedge monitor pops and compares them.
module tb_ysyx_22040632_div_ctrl;
   import ysyx_22040632_div_pkg::*;

   logic        clk = 1'b0;
   logic        rrst_n, flush, op_valid, wb_ena;
   logic [2:0]  op;
   logic [4:0]  op_rd, wb_addr, wr_addr;
   logic [63:0] op_src1, op_src2, wb_data, wr_data;
   logic        alu_busy, wr_ena;

   ysyx_22040632_div_ctrl #(.XLEN(64), .CNT_W(7)) dut (
      .clk(clk), .rrst_n(rrst_n), .flush(flush), .op_valid(op_valid), .op(op),
      .op_rd(op_rd), .op_src1(op_src1), .op_src2(op_src2), .alu_busy(alu_busy),
      .wb_ena(wb_ena), .wb_addr(wb_addr), .wb_data(wb_data),
      .wr_ena(wr_ena), .wr_addr(wr_addr), .wr_data(wr_data)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [4:0]  addr;
      logic [63:0] data;
      int unsigned cyc;
   } exp_t;

   exp_t        sb_q[$];
   exp_t        mon_e;
   int          errors = 0;
   int          checks = 0;
   int          writes = 0;
   int          exp_writes = 0;
   int unsigned cyc = 0;
   bit          mon_en = 1'b0;

   always @(posedge clk) cyc++;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // monitor: normal writeback passes through; divider writes go to the scoreboard
   always @(negedge clk) begin
      if (mon_en) begin
         if (wb_ena) begin
            check("wb_pass_ena", {63'd0, wr_ena}, 64'd1);
            check("wb_pass_addr", {59'd0, wr_addr}, {59'd0, wb_addr});
            check("wb_pass_data", wr_data, wb_data);
         end else if (wr_ena) begin
            writes++;
            if (sb_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_write: addr %0d data %h but none expected", wr_addr, wr_data);
            end else begin
               mon_e = sb_q.pop_front();
               check("div_addr", {59'd0, wr_addr}, {59'd0, mon_e.addr});
               check("div_data", wr_data, mon_e.data);
               check("div_cycle", {32'd0, cyc}, {32'd0, mon_e.cyc});
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // present one op for one cycle; returns in cycle N+1
   task automatic issue(input logic [2:0] o, input logic [4:0] rd, input logic [63:0] a,
                        input logic [63:0] b, input logic [63:0] exp, input int lat, input bit push);
      op_valid = 1'b1; op = o; op_rd = rd; op_src1 = a; op_src2 = b;
      if (push) begin
         sb_q.push_back('{rd, exp, cyc + lat});
         exp_writes++;
      end
      @(negedge clk);
      check("busy_accept", {63'd0, alu_busy}, 64'd1);
      tick();
      op_valid = 1'b0;
   endtask

   task automatic wait_writes();
      int k = 0;
      while (writes < exp_writes && k < 200) begin
         tick();
         k++;
      end
      check("write_seen", 64'(writes), 64'(exp_writes));
      tick();
   endtask

   task automatic expect_silence(input int n);
      int w0 = writes;
      repeat (n) tick();
      check("no_write", 64'(writes), 64'(w0));
      check("idle_busy", {63'd0, alu_busy}, 64'd0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rrst_n = 1'b0; flush = 1'b0; op_valid = 1'b0; op = 3'd0; op_rd = 5'd0;
      op_src1 = 64'd0; op_src2 = 64'd0; wb_ena = 1'b0; wb_addr = 5'd0; wb_data = 64'd0;
      tick();
      mon_en = 1'b1;
      tick();
      @(negedge clk);
      check("rst_busy", {63'd0, alu_busy}, 64'd0);
      check("rst_wr_ena", {63'd0, wr_ena}, 64'd0);
      check("rst_wr_addr", {59'd0, wr_addr}, 64'd0);
      check("rst_wr_data", wr_data, 64'd0);
      tick();
      wb_ena = 1'b1; wb_addr = 5'd4; wb_data = 64'h0000_0000_DEAD_BEEF;
      tick();
      wb_ena = 1'b0; wb_addr = 5'd0; wb_data = 64'd0;
      rrst_n = 1'b1;
      tick();

      issue(OP_DIV,   5'd5, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 67, 1'b1); wait_writes();
      issue(OP_REM,   5'd6, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 67, 1'b1); wait_writes();
      issue(OP_DIVU,  5'd7, 64'h1234, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 2, 1'b1);  wait_writes();
      issue(OP_REMU,  5'd8, 64'h1234, 64'd0, 64'h0000_0000_0000_1234, 2, 1'b1);  wait_writes();
      issue(OP_DIV,   5'd9, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
            64'h8000_0000_0000_0000, 2, 1'b1); wait_writes();
      issue(OP_DIVW,  5'd11, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
            64'hFFFF_FFFF_8000_0000, 2, 1'b1); wait_writes();
      issue(OP_DIV,   5'd12, 64'd20, -64'sd3, 64'hFFFF_FFFF_FFFF_FFFA, 67, 1'b1); wait_writes();
      issue(OP_REMW,  5'd13, 64'h0000_0000_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 35, 1'b1);
      wait_writes();
      issue(OP_REMUW, 5'd14, 64'h0000_0000_FFFF_FFF9, 64'h10, 64'd9, 35, 1'b1); wait_writes();

      // DIVUW: busy through N+34, released in the write cycle N+35
      issue(OP_DIVUW, 5'd15, 64'h0000_0000_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 35, 1'b1);
      for (int i = 1; i <= 34; i++) begin
         @(negedge clk);
         check("divuw_busy", {63'd0, alu_busy}, 64'd1);
      end
      @(negedge clk);
      check("divuw_release", {63'd0, alu_busy}, 64'd0);
      tick();
      wait_writes();

      // three cycles of writeback contention delay the divider write by three
      issue(OP_DIVU, 5'd16, 64'd100, 64'd7, 64'd14, 70, 1'b1);
      repeat (66) tick();
      for (int i = 0; i < 3; i++) begin
         wb_ena = 1'b1; wb_addr = 5'd3; wb_data = 64'hA0 + 64'(i);
         @(negedge clk);
         check("contend_busy", {63'd0, alu_busy}, 64'd1);
         tick();
      end
      wb_ena = 1'b0; wb_addr = 5'd0; wb_data = 64'd0;
      wait_writes();

      // flush while idle blocks acceptance
      op_valid = 1'b1; flush = 1'b1; op = OP_DIVU; op_rd = 5'd17; op_src1 = 64'd9; op_src2 = 64'd3;
      tick();
      op_valid = 1'b0; flush = 1'b0;
      @(negedge clk);
      check("idle_flush_busy", {63'd0, alu_busy}, 64'd0);
      expect_silence(80);

      // flush in CALC at N+10
      issue(OP_DIV, 5'd10, 64'd1000, 64'd3, 64'd0, 0, 1'b0);
      repeat (9) tick();
      flush = 1'b1;
      @(negedge clk);
      check("calc_busy", {63'd0, alu_busy}, 64'd1);
      tick();
      flush = 1'b0;
      @(negedge clk);
      check("flush_busy_drop", {63'd0, alu_busy}, 64'd0);
      expect_silence(80);

      // reset pulse mid-CALC
      issue(OP_DIVU, 5'd18, 64'd1000, 64'd3, 64'd0, 0, 1'b0);
      repeat (20) tick();
      rrst_n = 1'b0;
      tick();
      rrst_n = 1'b1;
      @(negedge clk);
      check("rst_calc_busy", {63'd0, alu_busy}, 64'd0);
      expect_silence(80);

      // rd == 0 never writes; next op still proceeds
      issue(OP_DIVU, 5'd0, 64'd5, 64'd0, 64'd0, 0, 1'b0);
      expect_silence(10);
      issue(OP_DIVU, 5'd19, 64'd100, 64'd7, 64'd14, 67, 1'b1); wait_writes();

      check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
